// File: rtl/k_fifo_2deep_ctrl_pkg.sv
// k_fifo_2deep_ctrl_pkg: shared occupancy constants and default data width
// for the two-entry FIFO controller.
`default_nettype none

package k_fifo_2deep_ctrl_pkg;

  localparam int         DATA_SIZE_DEFAULT = 8;
  localparam logic [1:0] CNT_EMPTY         = 2'd0;
  localparam logic [1:0] CNT_FULL          = 2'd2;

endpackage

`default_nettype wire

// File: rtl/k_dp_2deep_ram_t1.sv
// k_dp_2deep_ram_t1: two-entry RAM with one synchronous write port and one
// combinational read port; storage is intentionally not reset.
`default_nettype none

module k_dp_2deep_ram_t1
  import k_fifo_2deep_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 wen,
  input  logic                 waddr,
  input  logic                 raddr,
  input  logic [DATA_SIZE-1:0] d,
  output logic [DATA_SIZE-1:0] q
);

  logic [DATA_SIZE-1:0] mem_q [2];
  logic [DATA_SIZE-1:0] mem_d [2];

  always_comb begin
    mem_d = mem_q;
    if (wen) begin
      mem_d[waddr] = d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign q = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/k_fifo_2deep_ctrl.sv
// k_fifo_2deep_ctrl: two-entry valid/ready FIFO controller with flush; ready
// and valid depend only on registered occupancy, so there is no fall-through.
`default_nettype none

module k_fifo_2deep_ctrl
  import k_fifo_2deep_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           count,
  output logic                 full,
  output logic                 empty
);

  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;
  logic       ram_wen;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == CNT_EMPTY);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = CNT_EMPTY;
    end else begin
      if (push) wptr_d = !wptr_q;
      if (pop)  rptr_d = !rptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= CNT_EMPTY;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Gating with rst_n keeps a push presented during reset out of storage.
  assign ram_wen = push & !flush & rst_n;

  k_dp_2deep_ram_t1 #(
    .DATA_SIZE (DATA_SIZE)
  ) u_ram (
    .clk   (clk),
    .wen   (ram_wen),
    .waddr (wptr_q),
    .raddr (rptr_q),
    .d     (in_data),
    .q     (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_k_fifo_2deep_ctrl.sv
// tb_k_fifo_2deep_ctrl: directed vectors plus a randomised scoreboard run
// for the two-entry FIFO controller.
`default_nettype none

module tb_k_fifo_2deep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  k_fifo_2deep_ctrl #(.DATA_SIZE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs across a rising edge; outputs are sampled #1 later.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  logic [7:0] model_q[$];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_count", count, 2'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;

    // Fill to full, third push refused
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    check("one_out_valid", out_valid, 1'b1);
    check("one_out_data", out_data, 8'hA1);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    check("full_full", full, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    check("full_count", count, 2'd2);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    check("refused_count", count, 2'd2);
    check("refused_head", out_data, 8'hA1);

    // Drain in order; push at full with a pop must still be refused
    cyc(1'b1, 8'hC3, 1'b1, 1'b0);
    check("pop1_count", count, 2'd1);
    check("pop1_data", out_data, 8'hB2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", empty, 1'b1);
    check("drain_out_valid", out_valid, 1'b0);

    // Streaming at count == 1
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      check("stream_data", out_data, 32'(i - 1));
      cyc(1'b1, 8'(i), 1'b1, 1'b0);
      check("stream_count", count, 2'd1);
    end
    check("stream_last", out_data, 8'h06);

    // Flush at full overrides push and pop
    cyc(1'b1, 8'h07, 1'b0, 1'b0);
    check("pre_flush_count", count, 2'd2);
    cyc(1'b1, 8'h99, 1'b1, 1'b1);
    check("flush_count", count, 2'd0);
    check("flush_empty", empty, 1'b1);
    check("flush_in_ready", in_ready, 1'b1);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    check("post_flush_valid", out_valid, 1'b1);
    check("post_flush_data", out_data, 8'h5A);

    // Reset mid-operation drops a concurrent push
    rst_n = 1'b0;
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("midrst_count", count, 2'd0);
    check("midrst_out_valid", out_valid, 1'b0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    check("post_rst_data", out_data, 8'h11);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_empty", empty, 1'b1);

    // Random valid/ready against a queue model
    for (int n = 0; n < 10000; n++) begin
      logic iv, ordy, m_push, m_pop;
      logic [7:0] d;
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      check("rnd_count", count, 32'(model_q.size()));
      check("rnd_out_valid", out_valid, model_q.size() != 0);
      check("rnd_in_ready", in_ready, model_q.size() < 2);
      if (model_q.size() != 0) check("rnd_out_data", out_data, model_q[0]);
      m_push = iv && (model_q.size() < 2);
      m_pop  = ordy && (model_q.size() != 0);
      cyc(iv, d, ordy, 1'b0);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/k_fifo_2deep_ctrl.md
K_FIFO_2DEEP_CTRL -- requirements
Module: k_fifo_2deep_ctrl

Interface
REQ-001 Parameter: DATA_SIZE, default 8, data width in bits.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 flush  input  1  synchronous clear of occupancy; entry contents are not cleared.
REQ-005 in_data  input  DATA_SIZE  write-side data.
REQ-006 in_valid  input  1  write side presents in_data.
REQ-007 in_ready  output  1  controller can accept a word.
REQ-008 out_data  output  DATA_SIZE  head-of-queue data.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  read side consumes the head word.
REQ-011 count  output  2  occupancy, 0..2.
REQ-012 full  output  1  count == 2.
REQ-013 empty  output  1  count == 0.

Function
REQ-014 push SHALL be defined as in_valid & in_ready; pop SHALL be defined as out_valid & out_ready.
REQ-015 The block SHALL hold two entries with a 1-bit write pointer (wptr) and a 1-bit read pointer (rptr).
REQ-016 in_ready SHALL equal !full, with no combinational path from out_ready; a push is never accepted while full, even if a pop occurs in the same cycle.
REQ-017 out_valid SHALL equal !empty, with no combinational path from in_valid; there is no fall-through.
REQ-018 On push, entry[wptr] SHALL be written with in_data at the clock edge, and wptr SHALL toggle.
REQ-019 On pop, rptr SHALL toggle at the clock edge.
REQ-020 out_data SHALL be entry[rptr], read combinationally.
REQ-021 Latency: a word pushed at edge N SHALL appear with out_valid=1 after edge N, so it is poppable in cycle N+1.
REQ-022 count SHALL be updated as follows: push only increments; pop only decrements; push and pop together leave count unchanged and toggle both pointers.
REQ-023 Push and pop together SHALL be possible only at count == 1.
REQ-024 Pointer wrap: toggling from 1 SHALL return the pointer to 0, preserving order across wraps.
REQ-025 flush=1 SHALL force wptr=0, rptr=0 and count=0 at the edge; it overrides push and pop, and no write occurs that cycle.
REQ-026 out_data SHALL be don't-care whenever out_valid=0.
REQ-027 in_data and out_ready SHALL be ignored when not part of a push or pop.

Reset
REQ-028 With rst_n=0 at a posedge, the block SHALL set wptr=0, rptr=0 and count=0, giving in_ready=1, out_valid=0, full=0, empty=1.
REQ-029 Reset SHALL override flush, push and pop; a push presented during reset SHALL be dropped.
REQ-030 Entry storage SHALL NOT be reset.
REQ-031 Reset asserted mid-operation, with any count, SHALL empty the queue on that edge.

Structure
REQ-032 Storage SHALL be the team's existing 2-entry dual-port RAM k_dp_2deep_ram_t1, instantiated once and driven as follows: wen=push&!flush&rst_n, waddr=wptr, raddr=rptr, d=in_data, q=out_data.
REQ-033 Pointer, count and handshake logic SHALL live in k_fifo_2deep_ctrl itself; no other sub-modules.
REQ-034 The shared package SHALL hold the occupancy constants CNT_EMPTY=2'd0 and CNT_FULL=2'd2 and the default DATA_SIZE.

Verification
REQ-035 Reset, then push 8'hA1, 8'hB2 with out_ready=0: full=1, in_ready=0, count=2; a third push of 8'hC3 is refused and out_data=8'hA1.
REQ-036 From full, with out_ready=1 for two cycles: pops yield 8'hA1 then 8'hB2, then empty=1 and out_valid=0.
REQ-037 Streaming with count=1 and in_valid=out_ready=1 for 6 cycles on data 8'h01..8'h06: count stays 1, outputs come in order 8'h00-prefix sequence with no loss, and pointers wrap three times.
REQ-038 At count=2, assert flush together with in_valid and out_ready: next cycle count=0, empty=1, in_ready=1; a subsequent push of 8'h5A is read back as 8'h5A.
REQ-039 At count=1, assert rst_n=0 together with a push of 8'hFF: next cycle count=0, out_valid=0, and 8'hFF is never output.
REQ-040 Random valid/ready for 10k cycles against a scoreboard: order preserved, no push while full, no pop while empty, and count == pushes - pops.
